// File: rtl/div_pkg.sv
// Shared types and constants for the multicycle divider.
package div_pkg;

  localparam int unsigned DefaultWidth = 64;

  typedef enum logic [1:0] {
    Idle = 2'd0,
    Calc = 2'd1,
    Done = 2'd2
  } state_e;

endpackage

// File: rtl/div_step.sv
// One restoring radix-2 division step: shift in a dividend bit, subtract the divisor if it fits.
module div_step
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             dvd_bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted;

  // Compare on WIDTH+1 bits; the difference always fits in WIDTH bits when taken.
  always_comb begin
    shifted = {rem_i, dvd_bit_i};
    q_bit_o = (shifted >= {1'b0, divisor_i});
    rem_o   = q_bit_o ? (shifted[WIDTH-1:0] - divisor_i) : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/multicycle_divider.sv
// Unsigned restoring divider: one quotient bit per cycle, valid/ready on both sides.
module multicycle_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  // Holds the dividend at accept; dividend bits shift out of the top while quotient bits
  // shift in at the bottom, so it ends up holding the quotient.
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvsr_q, dvsr_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_q;

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem_i     (rem_q),
    .dvd_bit_i (quo_q[WIDTH-1]),
    .divisor_i (dvsr_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_q)
  );

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      Idle: begin
        if (in_valid) begin
          dvsr_d = divisor;
          if (divisor == '0) begin
            quo_d   = '1;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            cnt_d   = '0;
            state_d = Done;
          end else begin
            quo_d   = dividend;
            rem_d   = '0;
            dbz_d   = 1'b0;
            cnt_d   = CntW'(WIDTH);
            state_d = Calc;
          end
        end
      end
      Calc: begin
        rem_d = step_rem;
        quo_d = {quo_q[WIDTH-2:0], step_q};
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = Done;
        end
      end
      Done: begin
        if (out_ready) begin
          state_d = Idle;
        end
      end
      default: state_d = Idle;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= Idle;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == Idle);
  assign out_valid   = (state_q == Done);
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_multicycle_divider.sv
// Self-checking bench for multicycle_divider at WIDTH = 64.
module tb_multicycle_divider;

  localparam int unsigned W = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_cmp = 0;
  int n_err = 0;

  multicycle_divider #(
    .WIDTH(W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    int           lat;
  } vec_t;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Present operands, count edges from the accept edge (counted as 1) until out_valid.
  // in_valid stays high with junk operands during the operation to prove it is ignored.
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic dbz, output int lat);
    int g;
    g = 0;
    while (!in_ready && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    if (!in_ready) check("in_ready_wait", {63'd0, in_ready}, 64'd1);
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    @(posedge clk); #1;
    dividend = {$urandom, $urandom};
    divisor  = {$urandom, $urandom};
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    q   = quotient;
    r   = remainder;
    dbz = div_by_zero;
  endtask

  // Consume the result and confirm the return to IDLE one edge later.
  task automatic release_result(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_in_ready_after"}, {63'd0, in_ready}, 64'd1);
    check({name, "_out_valid_after"}, {63'd0, out_valid}, 64'd0);
  endtask

  initial begin
    vec_t         vecs[5];
    logic [W-1:0] all1;
    logic [W-1:0] q, r, a, b, eq, er;
    logic         dbz;
    int           lat, sel;

    all1 = '1;
    vecs[0] = '{a: 64'd100, b: 64'd7,  q: 64'd14, r: 64'd2, dbz: 1'b0, lat: 65};
    vecs[1] = '{a: 64'd5,   b: 64'd0,  q: all1,   r: 64'd5, dbz: 1'b1, lat: 1};
    vecs[2] = '{a: 64'd3,   b: 64'd10, q: 64'd0,  r: 64'd3, dbz: 1'b0, lat: 65};
    vecs[3] = '{a: all1,    b: 64'd1,  q: all1,   r: 64'd0, dbz: 1'b0, lat: 65};
    vecs[4] = '{a: all1,    b: all1,   q: 64'd1,  r: 64'd0, dbz: 1'b0, lat: 65};

    // Reset state while rst_n is low.
    #12;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_quotient", quotient, 64'd0);
    check("rst_remainder", remainder, 64'd0);
    check("rst_dbz", {63'd0, div_by_zero}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors.
    for (int i = 0; i < 5; i++) begin
      do_op(vecs[i].a, vecs[i].b, q, r, dbz, lat);
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'(vecs[i].lat));
      check($sformatf("vec%0d_quotient", i), q, vecs[i].q);
      check($sformatf("vec%0d_remainder", i), r, vecs[i].r);
      check($sformatf("vec%0d_dbz", i), {63'd0, dbz}, {63'd0, vecs[i].dbz});
      release_result($sformatf("vec%0d", i));
    end

    // Back-pressure: result must hold while out_ready stays low.
    do_op(64'd1000, 64'd9, q, r, dbz, lat);
    check("hold_latency", 64'(lat), 64'd65);
    for (int i = 0; i < 10; i++) begin
      check("hold_quotient", quotient, 64'd111);
      check("hold_remainder", remainder, 64'd1);
      check("hold_dbz", {63'd0, div_by_zero}, 64'd0);
      check("hold_in_ready", {63'd0, in_ready}, 64'd0);
      check("hold_out_valid", {63'd0, out_valid}, 64'd1);
      @(posedge clk); #1;
    end
    check("hold_in_ready_pre", {63'd0, in_ready}, 64'd0);
    release_result("hold");

    // Reset in the middle of a calculation.
    dividend = 64'd123456789;
    divisor  = 64'd77;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
    end
    check("mid_busy", {63'd0, in_ready}, 64'd0);
    rst_n = 1'b0;
    #2;
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("mid_rst_quotient", quotient, 64'd0);
    check("mid_rst_remainder", remainder, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(64'd50, 64'd5, q, r, dbz, lat);
    check("post_rst_latency", 64'(lat), 64'd65);
    check("post_rst_quotient", q, 64'd10);
    check("post_rst_remainder", r, 64'd0);
    check("post_rst_dbz", {63'd0, dbz}, 64'd0);
    release_result("post_rst");

    // Random back-to-back operations against plain arithmetic.
    for (int i = 0; i < 1000; i++) begin
      a   = {$urandom, $urandom};
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      b = '0;
      else if (sel <= 3) b = 64'($urandom_range(1, 1000));
      else if (sel <= 6) b = {32'd0, $urandom};
      else               b = {$urandom, $urandom};
      if (sel == 9) a = a >> $urandom_range(0, 63);
      if (b == '0) begin
        eq = '1;
        er = a;
      end else begin
        eq = a / b;
        er = a % b;
      end
      do_op(a, b, q, r, dbz, lat);
      check("rand_latency", 64'(lat), (b == '0) ? 64'd1 : 64'd65);
      check("rand_quotient", q, eq);
      check("rand_remainder", r, er);
      check("rand_dbz", {63'd0, dbz}, {63'd0, (b == '0)});
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_divider.md
MULTICYCLE_DIVIDER -- requirements
Module: multicycle_divider

Interface
REQ-001 The module SHALL have parameter WIDTH, default 64, giving the operand and result width in bits.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port in_valid, input, 1 bit: operands present.
REQ-005 The module SHALL have port in_ready, output, 1 bit: divider can accept operands.
REQ-006 The module SHALL have port dividend, input, WIDTH bits, unsigned.
REQ-007 The module SHALL have port divisor, input, WIDTH bits, unsigned.
REQ-008 The module SHALL have port out_valid, output, 1 bit: result present.
REQ-009 The module SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-010 The module SHALL have port quotient, output, WIDTH bits.
REQ-011 The module SHALL have port remainder, output, WIDTH bits.
REQ-012 The module SHALL have port div_by_zero, output, 1 bit: the current result came from divisor == 0.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-015 An accept SHALL occur on an edge with IDLE, in_valid = 1 and in_ready = 1; on that edge the block SHALL register both operands and clear the partial remainder.
REQ-016 On an accept with divisor != 0, the FSM SHALL go IDLE -> CALC and load the iteration counter with WIDTH.
REQ-017 In CALC, the block SHALL perform one restoring radix-2 step per cycle, MSB first: shift {rem, dividend bit} left, subtract divisor when rem >= divisor, and shift the resulting quotient bit in; the counter SHALL decrement each step.
REQ-018 The FSM SHALL go CALC -> DONE on the edge that performs the final step (counter == 1), so out_valid rises exactly WIDTH+1 edges after the accept edge.
REQ-019 On an accept with divisor == 0, the FSM SHALL go IDLE -> DONE directly, with quotient = all ones, remainder = dividend and div_by_zero = 1 (out_valid high 1 edge after accept).
REQ-020 Results SHALL satisfy dividend = quotient*divisor + remainder and remainder < divisor for every divisor != 0; no intermediate value SHALL exceed WIDTH+1 bits.
REQ-021 In DONE, quotient, remainder and div_by_zero SHALL hold stable while out_ready = 0.
REQ-022 In DONE with out_ready = 1, the FSM SHALL return to IDLE on the next edge, and in_ready SHALL be 1 the cycle after; there is no same-cycle result/operand overlap.
REQ-023 in_valid in CALC or DONE SHALL be ignored; operand changes after accept SHALL not affect the result.
REQ-024 div_by_zero SHALL be 0 for every result with divisor != 0.

Reset
REQ-025 While rst_n = 0, the block SHALL, independent of clk: set the state to IDLE, in_ready = 1, out_valid = 0, quotient = 0, remainder = 0, div_by_zero = 0, and counter = 0.
REQ-026 Reset asserted mid-CALC or in DONE SHALL abort the operation and discard the result; the first accept after rst_n rises SHALL behave as from power-up.

Structure
REQ-027 Shared package div_pkg SHALL hold the state enum type (IDLE/CALC/DONE) and the default WIDTH constant.
REQ-028 The single restoring iteration SHALL be a combinational sub-module div_step (inputs rem, dividend bit and divisor; outputs next rem and quotient bit), instantiated once.
REQ-029 The counter width SHALL be $clog2(WIDTH+1).

Verification
REQ-030 The bench SHALL check: 100 / 7, WIDTH = 64 -> out_valid 65 edges after accept, quotient = 14, remainder = 2, div_by_zero = 0.
REQ-031 The bench SHALL check: 5 / 0 -> out_valid 1 edge after accept, quotient = 0xFFFF_FFFF_FFFF_FFFF, remainder = 5, div_by_zero = 1.
REQ-032 The bench SHALL check: 3 / 10 -> quotient = 0, remainder = 3; and 2^64-1 / 1 -> quotient = 2^64-1, remainder = 0.
REQ-033 The bench SHALL check: 1000 / 9 with out_ready held 0 for 10 cycles -> outputs stable at 111 / 1 throughout, and in_ready = 0 until 1 edge after out_ready = 1.
REQ-034 The bench SHALL check: rst_n pulsed low at CALC cycle 30 -> out_valid = 0 and in_ready = 1 immediately; a following 50 / 5 -> quotient 10, remainder 0 at 65 edges.
REQ-035 The bench SHALL run 1000 random back-to-back operand pairs and check each result against the reference model q = a / b, r = a % b.
